// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: FSM encoding, channel constants and the
// round-robin pick helper shared by the FIFO drain arbiter.
package fifo_drain_pkg;

  localparam int NR_CH = 8;
  localparam int CHW   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // First set bit searching upward from ptr+1, wrapping 7->0.
  function automatic logic [CHW-1:0] rr_pick(
    input logic [NR_CH-1:0] req,
    input logic [CHW-1:0]   ptr
  );
    logic [CHW-1:0] idx;
    logic [CHW-1:0] pick;
    logic           found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NR_CH; i++) begin
      idx = ptr + CHW'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_drain_arb_skid.sv
// fifo_drain_skid: 2-entry valid/ready skid buffer between the
// FIFO RAM read and the output stream; count feeds the issue check.
module fifo_drain_skid #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr;
  logic         rd;
  logic         pop;

  assign out_vld = (count != 2'd0);
  assign pop     = out_vld & out_rdy;
  assign out_dat = mem[rd];

  // Upstream only pushes when an entry is free, so no overflow path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr     <= 1'b0;
      rd     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= push_dat;
        wr      <= ~wr;
      end
      if (pop) begin
        rd <= ~rd;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb: round-robin drain of the 8-channel shared FIFO.
// Define FIFO_DRAIN_PRIO0_EN to give channel 0 strict priority.
module fifo_drain_arb
  import fifo_drain_pkg::*;
#(
  parameter int DW        = 36,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ch_en_i,
  input  logic [7:0]       b_fifo_empty_i,
  output logic             b_re_o,
  output logic [2:0]       b_fifo_sel_o,
  input  logic [DW-1:0]    b_dat_i,
  output logic [DW-1:0]    o_dat,
  output logic [2:0]       o_ch,
  output logic             o_last,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic             o_abort
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int SW = DW + CHW + 1;

  state_t          state;
  state_t          state_d;
  logic [CHW-1:0]  sel;
  logic [CHW-1:0]  sel_d;
  logic [CHW-1:0]  ptr;
  logic [CHW-1:0]  ptr_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic [NR_CH-1:0] req;
  logic [CHW-1:0]  gnt;
  logic [1:0]      skid_count;
  logic [SW-1:0]   skid_dat;
  logic            inflight;
  logic            slot_free;
  logic            ch_empty;
  logic            last;
  logic            re;
  logic            push;
  logic            abort;

  assign req = ~b_fifo_empty_i & ch_en_i;

`ifdef FIFO_DRAIN_PRIO0_EN
  assign gnt = req[0] ? '0 : rr_pick(req & 8'hFE, ptr);
`else
  assign gnt = rr_pick(req, ptr);
`endif

  assign ch_empty  = b_fifo_empty_i[sel];
  assign inflight  = (state == WAIT);
  assign slot_free = ({1'b0, skid_count} + {2'b00, inflight}) < 3'd2;
  assign last      = (cnt == CW'(BURST_LEN - 1));

  always_comb begin
    state_d = state;
    sel_d   = sel;
    ptr_d   = ptr;
    cnt_d   = cnt;
    re      = 1'b0;
    push    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req != '0) begin
          sel_d   = gnt;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ch_empty) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (slot_free) begin
          re      = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        push    = 1'b1;
        cnt_d   = cnt + CW'(1);
        ptr_d   = sel;
        state_d = last ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= 3'd7;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  // Strobes are masked by reset so a reset mid-burst issues nothing.
  assign b_re_o       = re & rst;
  assign o_abort      = abort & rst;
  assign b_fifo_sel_o = sel;

  fifo_drain_skid #(
    .W(SW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({b_dat_i, sel, last}),
    .out_dat  (skid_dat),
    .out_vld  (o_vld),
    .out_rdy  (o_rdy),
    .count    (skid_count)
  );

  assign o_dat  = skid_dat[SW-1 -: DW];
  assign o_ch   = skid_dat[CHW:1];
  assign o_last = skid_dat[0];

endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb_fifo_drain_arb: queue-based FIFO emulator and burst-level
// reference model for fifo_drain_arb.
module tb_fifo_drain_arb;

  localparam int DW = 36;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    ch_en_i = 8'hFF;
  logic [7:0]    b_fifo_empty_i = 8'hFF;
  logic          b_re_o;
  logic [2:0]    b_fifo_sel_o;
  logic [DW-1:0] b_dat_i = '0;
  logic [DW-1:0] o_dat;
  logic [2:0]    o_ch;
  logic          o_last;
  logic          o_vld;
  logic          o_rdy = 1'b0;
  logic          o_abort;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] mq [8][$];
  logic [DW+3:0] got_q[$];
  logic [DW+3:0] exp_q[$];
  int   exp_ab = 0;
  int   ab_cnt = 0;
  int   rd_cnt = 0;
  int   cyc = 0;
  int   c_re = -1;
  int   c_vld = -1;
  int   rdy_mode = 1;
  bit   b2b = 0;
  bit   prev_re = 0;
  logic rd_pend = 1'b0;
  logic [2:0] rd_ch = '0;

  always #5 clk = ~clk;

  fifo_drain_arb #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_en_i        (ch_en_i),
    .b_fifo_empty_i (b_fifo_empty_i),
    .b_re_o         (b_re_o),
    .b_fifo_sel_o   (b_fifo_sel_o),
    .b_dat_i        (b_dat_i),
    .o_dat          (o_dat),
    .o_ch           (o_ch),
    .o_last         (o_last),
    .o_vld          (o_vld),
    .o_rdy          (o_rdy),
    .o_abort        (o_abort)
  );

  always @(posedge clk) begin
    rd_pend <= b_re_o;
    rd_ch   <= b_fifo_sel_o;
    cyc     <= cyc + 1;
  end

  // FIFO emulator: RAM data one cycle after the strobe
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      nvec++;
      if (mq[rd_ch].size() == 0) begin
        nerr++;
        $display("FAIL underflow ch%0d: read issued, required no read", rd_ch);
      end else begin
        b_dat_i = mq[rd_ch].pop_front();
      end
    end
    for (int c = 0; c < 8; c++) b_fifo_empty_i[c] = (mq[c].size() == 0);
    case (rdy_mode)
      0:       o_rdy = 1'b0;
      1:       o_rdy = 1'b1;
      default: o_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (o_vld && o_rdy) got_q.push_back({o_dat, o_ch, o_last});
      if (o_vld && c_vld < 0) c_vld = cyc;
      if (o_abort) ab_cnt++;
      if (b_re_o) begin
        rd_cnt++;
        if (c_re < 0) c_re = cyc;
        if (prev_re) b2b = 1;
      end
      prev_re = b_re_o;
    end
  end

  task automatic clear_obs();
    got_q.delete();
    ab_cnt = 0; rd_cnt = 0; c_re = -1; c_vld = -1; b2b = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; ch_en_i = 8'hFF; rdy_mode = 1;
    for (int c = 0; c < 8; c++) mq[c].delete();
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    clear_obs();
  endtask

  task automatic fill(input int ch, input int n);
    for (int i = 0; i < n; i++)
      mq[ch].push_back({4'(ch), 32'($urandom)});
  endtask

  // Burst-level model: each grant takes up to BL words of one channel
  task automatic predict(input logic [7:0] en);
    int left[8];
    int tk[8];
    logic [7:0] req;
    int ptr;
    int g;
    exp_q.delete(); exp_ab = 0; ptr = 7;
    for (int c = 0; c < 8; c++) begin left[c] = mq[c].size(); tk[c] = 0; end
    for (int it = 0; it < 200; it++) begin
      for (int c = 0; c < 8; c++) req[c] = en[c] && (left[c] > 0);
      if (req == 8'h00) break;
      g = -1;
`ifdef FIFO_DRAIN_PRIO0_EN
      if (req[0]) g = 0;
`endif
      for (int i = 1; i <= 8 && g < 0; i++)
        if (req[(ptr + i) % 8]) g = (ptr + i) % 8;
      for (int k = 0; k < BL; k++) begin
        if (left[g] == 0) begin exp_ab++; break; end
        exp_q.push_back({mq[g][tk[g]], 3'(g), k == BL - 1});
        tk[g]++; left[g]--;
      end
      ptr = g;
    end
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (got_q.size() >= exp_q.size() && ab_cnt >= exp_ab) begin
        ok = 1; break;
      end
    end
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    nvec++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL rst_vld got %b want 0", o_vld); end
    nvec++; if (o_dat !== '0) begin nerr++; $display("FAIL rst_dat got %h want 0", o_dat); end
    nvec++; if (o_ch !== 3'd0) begin nerr++; $display("FAIL rst_ch got %0d want 0", o_ch); end
    nvec++; if (o_last !== 1'b0) begin nerr++; $display("FAIL rst_last got %b want 0", o_last); end
    nvec++; if (o_abort !== 1'b0) begin nerr++; $display("FAIL rst_abort got %b want 0", o_abort); end
    nvec++; if (b_re_o !== 1'b0) begin nerr++; $display("FAIL rst_re got %b want 0", b_re_o); end
  endtask

  task automatic test_single_ch();
    bit ok;
    apply_reset();
    fill(2, 6);
    predict(8'hFF);
    drain(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (ab_cnt != exp_ab) begin nerr++; $display("FAIL single_abort got %0d want %0d", ab_cnt, exp_ab); end
    nvec++; if (rd_cnt != 6) begin nerr++; $display("FAIL single_reads got %0d want 6", rd_cnt); end
    nvec++; if (b2b) begin nerr++; $display("FAIL single_gap got back-to-back reads want 1-cycle gap"); end
    nvec++; if (c_vld - c_re != 2) begin nerr++; $display("FAIL single_latency got %0d want 2", c_vld - c_re); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL single_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    fill(0, 8); fill(3, 4); fill(7, 4);
    predict(8'hFF);
    drain(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL rr_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rr_count got %0d want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (ab_cnt != exp_ab) begin nerr++; $display("FAIL rr_abort got %0d want %0d", ab_cnt, exp_ab); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rr_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW+3:0] e;
    apply_reset();
    rdy_mode = 0;
    fill(1, 8);
    predict(8'hFF);
    e = exp_q[0];
    repeat (20) @(posedge clk);
    @(negedge clk);
    nvec++; if (rd_cnt != 2) begin nerr++; $display("FAIL bp_reads got %0d want 2", rd_cnt); end
    nvec++; if (o_vld !== 1'b1) begin nerr++; $display("FAIL bp_vld got %b want 1", o_vld); end
    nvec++; if (o_dat !== e[DW+3:4]) begin nerr++; $display("FAIL bp_hold got %h want %h", o_dat, e[DW+3:4]); end
    @(posedge clk); #1;
    rdy_mode = 1;
    drain(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL bp_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    apply_reset();
    fill(0, 4); fill(3, 8); fill(5, 4);
    n = 0;
    for (int i = 0; i < 400 && n < 2; i++) begin
      @(negedge clk);
      if (b_re_o && b_fifo_sel_o == 3'd3) n++;
    end
    nvec++; if (n < 2) begin nerr++; $display("FAIL rmid_find got %0d ch3 reads want 2", n); end
    #1 rst = 1'b0;
    #1;
    nvec++; if (b_re_o !== 1'b0) begin nerr++; $display("FAIL rmid_re got %b want 0", b_re_o); end
    @(posedge clk); #1;
    fill(0, 2);
    @(negedge clk);
    nvec++; if (o_vld !== 1'b0) begin nerr++; $display("FAIL rmid_vld got %b want 0", o_vld); end
    nvec++; if (o_dat !== '0) begin nerr++; $display("FAIL rmid_dat got %h want 0", o_dat); end
    nvec++; if (b_re_o !== 1'b0) begin nerr++; $display("FAIL rmid_re2 got %b want 0", b_re_o); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_obs();
    predict(8'hFF);
    drain(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL rmid_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (ab_cnt != exp_ab) begin nerr++; $display("FAIL rmid_abort got %0d want %0d", ab_cnt, exp_ab); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rmid_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_disabled();
    bit ok;
    apply_reset();
    ch_en_i = 8'hFE;
    fill(0, 5); fill(5, 6);
    predict(8'hFE);
    drain(ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL dis_timeout got %0d words want %0d", got_q.size(), exp_q.size()); end
    nvec++; if (mq[0].size() != 5) begin nerr++; $display("FAIL dis_ch0 got %0d left want 5", mq[0].size()); end
    nvec++; if (ab_cnt != exp_ab) begin nerr++; $display("FAIL dis_abort got %0d want %0d", ab_cnt, exp_ab); end
    nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL dis_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      nvec++;
      if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL dis_word%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      ch_en_i = 8'($urandom);
      rdy_mode = 2;
      for (int c = 0; c < 8; c++) fill(c, $urandom_range(0, 9));
      predict(ch_en_i);
      drain(ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL rnd%0d_timeout got %0d words want %0d", it, got_q.size(), exp_q.size()); end
      nvec++; if (got_q.size() != exp_q.size()) begin nerr++; $display("FAIL rnd%0d_count got %0d want %0d", it, got_q.size(), exp_q.size()); end
      nvec++; if (ab_cnt != exp_ab) begin nerr++; $display("FAIL rnd%0d_abort got %0d want %0d", it, ab_cnt, exp_ab); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        nvec++;
        if (got_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd%0d_word%0d got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ch();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_disabled();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
